// File: rtl/bits_decider_if.sv
// Correlation-in / framed-bits-out bundle for bits_decider.
// The design drives the slave side; the upstream/test side drives the master side.
interface bits_decider_if #(
    parameter int LENGTH    = 64,
    parameter int SYM_WIDTH = 8,
    parameter int MAX_BITS  = 1023
);
    localparam int CORR_WIDTH = $clog2(LENGTH + 1);
    localparam int CNT_WIDTH  = $clog2(MAX_BITS + 1);

    logic [4*CORR_WIDTH-1:0] corr_dat;
    logic                    corr_vld;
    logic                    arm;
    logic [CORR_WIDTH-1:0]   cfg_threshold;
    logic [SYM_WIDTH-1:0]    cfg_peak_window;
    logic [SYM_WIDTH-1:0]    cfg_symbol_len;
    logic [CORR_WIDTH-1:0]   cfg_margin;
    logic [CNT_WIDTH-1:0]    cfg_max_bits;
    logic [SYM_WIDTH-1:0]    cfg_timeout;
    logic                    out_bit;
    logic                    out_vld;
    logic                    frame_start;
    logic                    frame_done;
    logic                    frame_err;
    logic [CNT_WIDTH-1:0]    bit_count;
    logic                    busy;

    modport master (
        output corr_dat, corr_vld, arm, cfg_threshold, cfg_peak_window,
               cfg_symbol_len, cfg_margin, cfg_max_bits, cfg_timeout,
        input  out_bit, out_vld, frame_start, frame_done, frame_err,
               bit_count, busy
    );

    modport slave (
        input  corr_dat, corr_vld, arm, cfg_threshold, cfg_peak_window,
               cfg_symbol_len, cfg_margin, cfg_max_bits, cfg_timeout,
        output out_bit, out_vld, frame_start, frame_done, frame_err,
               bit_count, busy
    );
endinterface

// File: rtl/bits_decider.sv
// Preamble peak lock and per-symbol bit slicer downstream of the bits correlator.
// Emits registered bits with frame start/done/error strobes.
module bits_decider #(
    parameter int LENGTH    = 64,
    parameter int SYM_WIDTH = 8,
    parameter int MAX_BITS  = 1023
) (
    input logic          clk,
    input logic          rst,
    bits_decider_if.slave bus
);
    localparam int CORR_WIDTH = $clog2(LENGTH + 1);
    localparam int CNT_WIDTH  = $clog2(MAX_BITS + 1);
    localparam int TMR_WIDTH  = SYM_WIDTH + 8;

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_PEAK, S_DATA} state_t;

    state_t                r_state, w_state_nx;
    logic [CORR_WIDTH-1:0] r_peak, w_peak_nx;
    logic [SYM_WIDTH-1:0]  r_age, w_age_nx;
    logic [SYM_WIDTH-1:0]  r_sym, w_sym_nx;
    logic [TMR_WIDTH-1:0]  r_timer, w_timer_nx;
    logic [CNT_WIDTH-1:0]  r_bit_count, w_bit_count_nx;

    logic                  r_out_bit, w_out_bit_nx;
    logic                  r_out_vld, w_out_vld_nx;
    logic                  r_frame_start, w_frame_start_nx;
    logic                  r_frame_done, w_frame_done_nx;
    logic                  r_frame_err, w_frame_err_nx;
    logic                  w_cap;

    logic [CORR_WIDTH-1:0] r_thr;
    logic [SYM_WIDTH-1:0]  r_pw;
    logic [SYM_WIDTH-1:0]  r_sl;
    logic [CORR_WIDTH-1:0] r_margin;
    logic [CNT_WIDTH-1:0]  r_maxb;
    logic [SYM_WIDTH-1:0]  r_tmo;

    logic [CORR_WIDTH-1:0] w_matches;
    logic [CORR_WIDTH-1:0] w_mism;
    logic [CORR_WIDTH:0]   w_diff;
    logic                  w_weak;
    logic [SYM_WIDTH-1:0]  w_sl_m1;
    logic [SYM_WIDTH-1:0]  w_lock_age;
    logic [TMR_WIDTH-1:0]  w_timer_inc;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic                  w_unused;

    assign w_matches = bus.corr_dat[CORR_WIDTH +: CORR_WIDTH];
    assign w_mism    = bus.corr_dat[2*CORR_WIDTH +: CORR_WIDTH];
    assign w_unused  = ^{bus.corr_dat[CORR_WIDTH-1:0], bus.corr_dat[3*CORR_WIDTH +: CORR_WIDTH]};

    assign w_diff      = (w_matches >= w_mism) ? ({1'b0, w_matches} - {1'b0, w_mism})
                                               : ({1'b0, w_mism} - {1'b0, w_matches});
    assign w_weak      = w_diff < {1'b0, r_margin};
    assign w_sl_m1     = r_sl - SYM_WIDTH'(1);
    assign w_lock_age  = (r_pw < w_sl_m1) ? r_pw : w_sl_m1;
    assign w_timer_inc = r_timer + TMR_WIDTH'(1);
    assign w_cnt_inc   = r_bit_count + CNT_WIDTH'(1);

    always_comb begin
        w_state_nx       = r_state;
        w_peak_nx        = r_peak;
        w_age_nx         = r_age;
        w_sym_nx         = r_sym;
        w_timer_nx       = r_timer;
        w_bit_count_nx   = r_bit_count;
        w_out_bit_nx     = 1'b0;
        w_out_vld_nx     = 1'b0;
        w_frame_start_nx = 1'b0;
        w_frame_done_nx  = 1'b0;
        w_frame_err_nx   = 1'b0;
        w_cap            = 1'b0;

        case (r_state)
            S_IDLE: begin
                // frame_done is high on the first IDLE cycle; an arm there is dropped
                if (bus.arm && !r_frame_done) begin
                    w_state_nx     = S_SEARCH;
                    w_bit_count_nx = '0;
                    w_timer_nx     = '0;
                    w_cap          = 1'b1;
                end
            end
            S_SEARCH: begin
                if (bus.corr_vld) begin
                    if (w_matches >= r_thr) begin
                        w_state_nx = S_PEAK;
                        w_peak_nx  = w_matches;
                        w_age_nx   = '0;
                    end else begin
                        w_timer_nx = w_timer_inc;
                        if (r_tmo != '0 && w_timer_inc == {r_tmo, 8'h00}) begin
                            w_frame_done_nx = 1'b1;
                            w_frame_err_nx  = 1'b1;
                            w_state_nx      = S_IDLE;
                        end
                    end
                end
            end
            S_PEAK: begin
                if (bus.corr_vld) begin
                    if (w_matches > r_peak) begin
                        w_peak_nx = w_matches;
                        w_age_nx  = '0;
                    end else begin
                        w_age_nx = r_age + SYM_WIDTH'(1);
                    end
                    // Preloading the symbol counter with the age aligns decisions to the peak sample
                    if (w_age_nx == w_lock_age) begin
                        w_frame_start_nx = 1'b1;
                        w_state_nx       = S_DATA;
                        w_sym_nx         = w_age_nx;
                    end
                end
            end
            S_DATA: begin
                if (bus.corr_vld) begin
                    if (r_sym == w_sl_m1) begin
                        w_sym_nx = '0;
                        if (w_weak) begin
                            w_frame_done_nx = 1'b1;
                            w_frame_err_nx  = (r_bit_count == '0);
                            w_state_nx      = S_IDLE;
                        end else begin
                            w_out_vld_nx   = 1'b1;
                            w_out_bit_nx   = (w_matches > w_mism);
                            w_bit_count_nx = w_cnt_inc;
                            if (w_cnt_inc == r_maxb) begin
                                w_frame_done_nx = 1'b1;
                                w_state_nx      = S_IDLE;
                            end
                        end
                    end else begin
                        w_sym_nx = r_sym + SYM_WIDTH'(1);
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_peak        <= '0;
            r_age         <= '0;
            r_sym         <= '0;
            r_timer       <= '0;
            r_bit_count   <= '0;
            r_out_bit     <= 1'b0;
            r_out_vld     <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_thr         <= '0;
            r_pw          <= '0;
            r_sl          <= '0;
            r_margin      <= '0;
            r_maxb        <= '0;
            r_tmo         <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_peak        <= w_peak_nx;
            r_age         <= w_age_nx;
            r_sym         <= w_sym_nx;
            r_timer       <= w_timer_nx;
            r_bit_count   <= w_bit_count_nx;
            r_out_bit     <= w_out_bit_nx;
            r_out_vld     <= w_out_vld_nx;
            r_frame_start <= w_frame_start_nx;
            r_frame_done  <= w_frame_done_nx;
            r_frame_err   <= w_frame_err_nx;
            if (w_cap) begin
                r_thr    <= bus.cfg_threshold;
                r_pw     <= bus.cfg_peak_window;
                r_sl     <= bus.cfg_symbol_len;
                r_margin <= bus.cfg_margin;
                r_maxb   <= (bus.cfg_max_bits == '0) ? CNT_WIDTH'(MAX_BITS) : bus.cfg_max_bits;
                r_tmo    <= bus.cfg_timeout;
            end
        end
    end

    assign bus.out_bit     = r_out_bit;
    assign bus.out_vld     = r_out_vld;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_err   = r_frame_err;
    assign bus.bit_count   = r_bit_count;
    assign bus.busy        = (r_state != S_IDLE);
endmodule
